mcp320x_spi_scan: RTL and testbench

Parametrised SPI master for the MCP3202, MCP3204 and MCP3208 12-bit ADC family. On each sample tick it sweeps a configurable set of channels, one CS frame per channel, and emits one tagged 12-bit word per conversion. It sits between the ADC pins and the ECG filter chain. Sample rate, SCK rate, CS-high time and device type are all set by parameters.

---
 rtl/mcp320x_spi_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_mcp320x_spi_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp320x_spi_scan.sv
`timescale 1ns/1ps
// mcp320x_spi_scan
//   SPI master for the MCP3202 / MCP3204 / MCP3208 12-bit ADCs. On every sample tick it
//   sweeps the enabled channels in ascending order, one CS frame per channel. Each
//   conversion is emitted as a 12-bit word tagged with its channel index.
//
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          enables the sample-tick counter (held at 0 while low)
//   miso        ADC data out
//   mosi        ADC data in (command bits)
//   sck         SPI clock, mode 0,0
//   cs          chip select, active low
//   data, ch    last converted word and its channel index
//   dv          one-cycle pulse when data/ch update
//   busy        high from sweep start through the final CS-high gap
//   overrun     one-cycle pulse when a tick arrives while busy (the tick is dropped)
module mcp320x_spi_scan #(
  parameter int unsigned ADC_TYPE      = 0,
  parameter int unsigned NUM_CH        = 2,
  parameter logic [7:0]  CH_MASK       = 8'h03,
  parameter bit          DIFF          = 1'b0,
  parameter int unsigned SCK_DIV       = 100,
  parameter int unsigned TCSH_CYC      = 50,
  parameter int unsigned SAMPLE_PERIOD = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        cs,
  output logic [11:0] data,
  output logic [2:0]  ch,
  output logic        dv,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned FRAME_SCK    = (ADC_TYPE == 0) ? 17 : 19;
  localparam int unsigned FIRST_DATA_K = (ADC_TYPE == 0) ? 5 : 7;
  localparam int unsigned HALF         = SCK_DIV / 2;
  localparam int unsigned TMR_MAX      = (SCK_DIV > TCSH_CYC) ? SCK_DIV : TCSH_CYC;
  localparam int unsigned TMR_W        = $clog2(TMR_MAX + 1);
  localparam int unsigned TICK_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [8:0]  NUM_CH_ONES  = (9'd1 << NUM_CH) - 9'd1;
  localparam logic [7:0]  VALID_MASK   = CH_MASK & NUM_CH_ONES[7:0];

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;     // SETUP/GAP length, SCK divider in SHIFT
  logic [4:0]        k_q, k_d;         // SCK period index within the frame
  logic [2:0]        cur_ch_q, cur_ch_d;
  logic [10:0]       shreg_q, shreg_d;
  logic [11:0]       data_q, data_d;
  logic [2:0]        ch_q, ch_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  logic [2:0]        first_ch, nxt_ch;
  logic              nxt_valid;
  logic [4:0]        cmd_word, cmd_shift;

  // Sample-tick counter
  always_comb begin
    tick = en && (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));
    if (!en || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Lowest enabled channel, and lowest enabled channel above the current one.
  // Scanning downwards leaves the lowest match in the outputs.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (VALID_MASK[i]) begin
        first_ch = 3'(i);
        if (3'(i) > cur_ch_q) begin
          nxt_ch    = 3'(i);
          nxt_valid = 1'b1;
        end
      end
    end
  end

  // Command bits, first-sent bit at [4]. Shifting by k leaves bit k at [4] and
  // naturally yields 0 once the command is exhausted.
  always_comb begin
    if (ADC_TYPE == 0) begin
      cmd_word = {1'b1, ~DIFF, cur_ch_d[0], 1'b1, 1'b0};
    end else begin
      cmd_word = {1'b1, ~DIFF, cur_ch_d};
    end
    cmd_shift = cmd_word << k_d;
  end

  // Next state and registered-output decode
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    k_d       = k_q;
    cur_ch_d  = cur_ch_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ch_d      = ch_q;
    dv_d      = 1'b0;
    overrun_d = tick && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (tick && (VALID_MASK != 8'h00)) begin
          state_d  = StSetup;
          tmr_d    = '0;
          cur_ch_d = first_ch;
        end
      end

      StSetup: begin
        if (tmr_q == TMR_W'(HALF - 1)) begin
          state_d = StShift;
          tmr_d   = '0;
          k_d     = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      StShift: begin
        // Sample on the edge where the divider enters the high half, i.e. the
        // same edge at which the registered sck rises.
        if (tmr_q == TMR_W'(HALF - 1) && k_q >= 5'(FIRST_DATA_K)) begin
          shreg_d = {shreg_q[9:0], miso};
          if (k_q == 5'(FRAME_SCK - 1)) begin
            data_d = {shreg_q, miso};
            ch_d   = cur_ch_q;
            dv_d   = 1'b1;
          end
        end
        if (tmr_q == TMR_W'(SCK_DIV - 1)) begin
          tmr_d = '0;
          if (k_q == 5'(FRAME_SCK - 1)) begin
            state_d = StGap;
          end else begin
            k_d = k_q + 5'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      StGap: begin
        if (tmr_q == TMR_W'(TCSH_CYC - 1)) begin
          tmr_d = '0;
          if (nxt_valid) begin
            state_d  = StSetup;
            cur_ch_d = nxt_ch;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    // Pin values are registered from the next state so they line up with state_q
    // and never glitch.
    cs_d   = !((state_d == StSetup) || (state_d == StShift));
    sck_d  = (state_d == StShift) && (tmr_d >= TMR_W'(HALF));
    mosi_d = (state_d == StShift) && cmd_shift[4];
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      k_q        <= '0;
      cur_ch_q   <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      k_q        <= k_d;
      cur_ch_q   <= cur_ch_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign data    = data_q;
  assign ch      = ch_q;
  assign dv      = dv_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mcp320x_spi_scan.sv
`timescale 1ns/1ps
// Bench for mcp320x_spi_scan: two instances (MCP3202 with channels 0,1; MCP3208 in
// pseudo-differential mode with channels 2,5,7 and a sweep longer than the sample
// period). A per-cycle reference derives pin timing from tick times with plain
// arithmetic; an ADC model serves random words and a scoreboard checks every dv.
module tb_mcp320x_spi_scan;

  localparam int unsigned SCK_DIV = 4;
  localparam int unsigned TCSH    = 3;
  localparam int unsigned SP      = 200;
  localparam int unsigned HALF    = SCK_DIV / 2;

  logic       clk = 1'b0;
  logic [1:0] rst_n_v;
  logic [1:0] en_v;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned AT    = (g == 0) ? 0 : 1;
    localparam int unsigned NCH   = (g == 0) ? 2 : 8;
    localparam logic [7:0]  MASK  = (g == 0) ? 8'h03 : 8'hA4;
    localparam bit          DF    = (g == 0) ? 1'b0 : 1'b1;
    localparam int unsigned FSCK  = (AT == 0) ? 17 : 19;
    localparam int unsigned CSLOW = HALF + FSCK * SCK_DIV;
    localparam int unsigned FC    = CSLOW + TCSH;

    logic        miso = 1'b0;
    logic        mosi, sck, cs, dv, busy, overrun;
    logic [11:0] data;
    logic [2:0]  ch;

    mcp320x_spi_scan #(
      .ADC_TYPE     (AT),
      .NUM_CH       (NCH),
      .CH_MASK      (MASK),
      .DIFF         (DF),
      .SCK_DIV      (SCK_DIV),
      .TCSH_CYC     (TCSH),
      .SAMPLE_PERIOD(SP)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n_v[g]),
      .en     (en_v[g]),
      .miso   (miso),
      .mosi   (mosi),
      .sck    (sck),
      .cs     (cs),
      .data   (data),
      .ch     (ch),
      .dv     (dv),
      .busy   (busy),
      .overrun(overrun)
    );

    int          chans[$];
    int unsigned nfr = 0;
    logic [14:0] exp_q[$];
    logic [11:0] word = '0;
    int unsigned n = 0;

    initial begin
      for (int i = 0; i < 8; i++) begin
        if (MASK[i] && i < NCH) chans.push_back(i);
      end
      nfr = 32'(chans.size());
    end

    // Command sequence as sent on the wire, first bit first.
    function automatic bit cmd_bit(input int unsigned k, input int unsigned chn);
      bit seq[$];
      seq = {1'b1, !DF};
      if (AT == 0) begin
        seq.push_back(chn[0]);
        seq.push_back(1'b1);
      end else begin
        seq.push_back(chn[2]);
        seq.push_back(chn[1]);
        seq.push_back(chn[0]);
      end
      return (k < 32'(seq.size())) ? seq[k] : 1'b0;
    endfunction

    // ADC: bit for SCK index k is presented after the falling edge preceding it.
    function automatic logic adc_bit(input int unsigned k);
      int unsigned null_k;
      null_k = (AT == 0) ? 4 : 6;
      if (k == null_k) return 1'b0;
      if (k > null_k && k <= null_k + 12) return word[null_k + 12 - k];
      return 1'($urandom);
    endfunction

    always @(negedge cs) begin
      n = 0;
      miso = 1'($urandom);
    end
    always @(posedge sck) n++;
    always @(negedge sck) miso = adc_bit(n);

    // Reference: sweep start times from ticks, pin values from frame offsets.
    int unsigned cnt = 0;
    int unsigned c = 0;
    int unsigned start = 0;
    bit          active = 1'b0;
    bit          ov_exp = 1'b0;

    always @(negedge clk) begin
      int unsigned o, j, k, dd;
      bit e_cs, e_sck, e_mosi, e_dv, e_busy, tick;
      c++;
      if (!rst_n_v[g]) begin
        cnt = 0;
        active = 1'b0;
        ov_exp = 1'b0;
        exp_q.delete();
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dv", 32'(dv), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
      end else begin
        if (active && (c - start) >= nfr * FC) active = 1'b0;
        e_cs = 1'b1;
        e_sck = 1'b0;
        e_mosi = 1'b0;
        e_dv = 1'b0;
        e_busy = active;
        if (active) begin
          o = (c - start) % FC;
          j = (c - start) / FC;
          if (o < CSLOW) begin
            e_cs = 1'b0;
            if (o == 0) begin
              word = 12'($urandom);
              exp_q.push_back({3'(chans[j]), word});
            end
            if (o >= HALF) begin
              k = (o - HALF) / SCK_DIV;
              dd = (o - HALF) % SCK_DIV;
              e_sck = (dd >= HALF);
              e_mosi = cmd_bit(k, 32'(chans[j]));
            end
            e_dv = (o == CSLOW - HALF);
          end
        end
        chk("cs", 32'(cs), 32'(e_cs));
        chk("sck", 32'(sck), 32'(e_sck));
        chk("mosi", 32'(mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("dv_timing", 32'(dv), 32'(e_dv));
        chk("overrun", 32'(overrun), 32'(ov_exp));
        tick = en_v[g] && (cnt == SP - 1);
        ov_exp = tick && e_busy;
        if (tick && !e_busy) begin
          active = 1'b1;
          start = c + 1;
        end
        cnt = (!en_v[g] || cnt == SP - 1) ? 0 : cnt + 1;
      end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
      logic [14:0] e;
      if (rst_n_v[g] && dv === 1'b1) begin
        chk("dv_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("dv_ch", 32'(ch), 32'(e[14:12]));
          chk("dv_data", 32'(data), 32'(e[11:0]));
        end
      end
    end
  end

  task automatic wait_a_cs_fall(output bit ok);
    bit seen_high;
    ok = 1'b0;
    seen_high = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (g_dut[0].cs) seen_high = 1'b1;
      else if (seen_high) ok = 1'b1;
    end
  endtask

  task automatic wait_a_busy_rise(output bit ok);
    bit seen_low;
    ok = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!g_dut[0].busy) seen_low = 1'b1;
      else if (seen_low) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    rst_n_v = 2'b00;
    en_v = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data_a", 32'(g_dut[0].data), 32'd0);
    chk("rst_ch_a", 32'(g_dut[0].ch), 32'd0);
    chk("rst_data_b", 32'(g_dut[1].data), 32'd0);
    chk("rst_ch_b", 32'(g_dut[1].ch), 32'd0);
    rst_n_v = 2'b11;
    en_v = 2'b11;
    repeat (1500) @(posedge clk);

    // Async reset on A while SCK index 9 is high.
    wait_a_cs_fall(ok);
    chk("cs_fall_found", 32'(ok), 32'd1);
    if (ok) begin
      repeat (HALF + 9 * SCK_DIV + HALF) @(posedge clk);
      #2;
      rst_n_v[0] = 1'b0;
      #1;
      chk("async_rst_cs", 32'(g_dut[0].cs), 32'd1);
      chk("async_rst_sck", 32'(g_dut[0].sck), 32'd0);
      chk("async_rst_mosi", 32'(g_dut[0].mosi), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n_v[0] = 1'b1;
    end
    repeat (500) @(posedge clk);

    // Drop en on A just after a sweep starts: the sweep still completes.
    wait_a_busy_rise(ok);
    chk("busy_rise_found", 32'(ok), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    en_v[0] = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    en_v[0] = 1'b1;
    repeat (700) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
